// File: rtl/reg_dump_streamer.sv
// Snapshots the whole register file on Start and streams it out one register
// per valid/ready beat, followed by an 8-bit wrapping checksum beat.
module reg_dump_streamer #(
    parameter int pw = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [8*(2**pw)-1:0]   RegsIn,
    input  logic                   Ready,
    output logic                   Valid,
    output logic [7:0]             DataOut,
    output logic [pw-1:0]          AddrOut,
    output logic                   Last,
    output logic                   Busy,
    output logic                   Done
);

    localparam int NREG = 2**pw;
    localparam logic [pw-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_CKSUM,
        S_DONE
    } state_t;

    state_t               state;
    logic [8*NREG-1:0]    snap;
    logic [pw-1:0]        idx;
    logic [7:0]           acc;
    logic                 accept;
    logic [7:0]           sum_next;
    logic [pw-1:0]        idx_next;

    function automatic logic [7:0] byte_at(input logic [8*NREG-1:0] s,
                                           input logic [pw-1:0]     i);
        return s[8*i +: 8];
    endfunction

    // Checksum is deliberately modulo 256; the carry is dropped.
    function automatic logic [7:0] add_wrap(input logic [7:0] a,
                                            input logic [7:0] b);
        return a + b;
    endfunction

    assign accept   = Valid && Ready;
    assign sum_next = add_wrap(acc, DataOut);
    assign idx_next = idx + 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            snap    <= '0;
            idx     <= '0;
            acc     <= '0;
            Valid   <= 1'b0;
            DataOut <= '0;
            AddrOut <= '0;
            Last    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start && !Abort) begin
                        snap    <= RegsIn;
                        idx     <= '0;
                        acc     <= '0;
                        Valid   <= 1'b1;
                        DataOut <= RegsIn[7:0];
                        AddrOut <= '0;
                        Last    <= 1'b0;
                        Busy    <= 1'b1;
                        state   <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (Abort) begin
                        Valid <= 1'b0;
                        Last  <= 1'b0;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (accept) begin
                        acc <= sum_next;
                        if (idx == LAST_IDX) begin
                            // Checksum beat carries the running sum including this beat.
                            DataOut <= sum_next;
                            AddrOut <= '0;
                            Last    <= 1'b1;
                            state   <= S_CKSUM;
                        end else begin
                            idx     <= idx_next;
                            AddrOut <= idx_next;
                            DataOut <= byte_at(snap, idx_next);
                        end
                    end
                end

                S_CKSUM: begin
                    if (Abort) begin
                        Valid <= 1'b0;
                        Last  <= 1'b0;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (accept) begin
                        Valid <= 1'b0;
                        Last  <= 1'b0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    Valid <= 1'b0;
                    Last  <= 1'b0;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: table of full dumps plus hand-written abort,
// restart-while-busy and asynchronous-reset sequences, checked via a beat scoreboard.
module tb_reg_dump_streamer;

    localparam int PW   = 4;
    localparam int NREG = 2**PW;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Abort;
    logic [8*NREG-1:0] RegsIn;
    logic              Ready;
    logic              Valid;
    logic [7:0]        DataOut;
    logic [PW-1:0]     AddrOut;
    logic              Last;
    logic              Busy;
    logic              Done;

    reg_dump_streamer #(.pw(PW)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Abort   (Abort),
        .RegsIn  (RegsIn),
        .Ready   (Ready),
        .Valid   (Valid),
        .DataOut (DataOut),
        .AddrOut (AddrOut),
        .Last    (Last),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          last;
        logic [PW-1:0] addr;
        logic [7:0]    data;
    } beat_t;

    typedef struct {
        logic [8*NREG-1:0] regs;
        bit                rand_ready;
        bit                corrupt;
        logic [7:0]        cksum;
        int                latency;
    } vec_t;

    beat_t sb[$];
    int    checks = 0;
    int    passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Beat monitor: pops the scoreboard on every accepted beat, and checks
    // that a stalled beat is held unchanged into the next cycle.
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    always @(negedge Clk) begin
        beat_t cur;
        beat_t exp;
        cur = '{last: Last, addr: AddrOut, data: DataOut};
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, Valid}, 32'd1);
                check("hold_beat", {19'd0, cur}, {19'd0, prev_beat});
            end
            if (Valid && Ready && !Abort) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", {19'd0, cur}, 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    check("beat", {19'd0, cur}, {19'd0, exp});
                end
            end
            prev_stall = Valid && !Ready && !Abort;
            prev_beat  = cur;
        end
    end

    task automatic push_dump(input logic [8*NREG-1:0] regs, input logic [7:0] cksum, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            sb.push_back('{last: 1'b0, addr: PW'(i), data: regs[8*i +: 8]});
        if (nbeats == NREG)
            sb.push_back('{last: 1'b1, addr: '0, data: cksum});
    endtask

    task automatic run_dump(input vec_t v, input string tag);
        int cyc;
        RegsIn = v.regs;
        push_dump(v.regs, v.cksum, NREG);
        @(posedge Clk); #1;
        Start = 1'b1;
        Ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        if (v.corrupt) RegsIn = {NREG{8'hAA}};
        while (!Done && cyc < 200) begin
            Ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge Clk); #1;
            cyc++;
        end
        check({tag, "_done"}, {31'd0, Done}, 32'd1);
        if (v.latency >= 0) check({tag, "_latency"}, cyc, v.latency);
        check({tag, "_valid_at_done"}, {31'd0, Valid}, 32'd0);
        Ready = 1'b1;
        @(posedge Clk); #1;
        check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    vec_t vecs[7];
    logic [8*NREG-1:0] inc_regs, ff_regs, m17_regs, zero_regs, h80_regs;

    initial begin
        int k;
        for (int i = 0; i < NREG; i++) begin
            inc_regs[8*i +: 8] = 8'(i + 1);
            m17_regs[8*i +: 8] = 8'(i * 17);
        end
        ff_regs   = {NREG{8'hFF}};
        zero_regs = '0;
        h80_regs  = {NREG{8'h80}};
        vecs[0] = '{regs: inc_regs,  rand_ready: 0, corrupt: 0, cksum: 8'h88, latency: 18};
        vecs[1] = '{regs: ff_regs,   rand_ready: 0, corrupt: 0, cksum: 8'hF0, latency: 18};
        vecs[2] = '{regs: inc_regs,  rand_ready: 1, corrupt: 0, cksum: 8'h88, latency: -1};
        vecs[3] = '{regs: inc_regs,  rand_ready: 0, corrupt: 1, cksum: 8'h88, latency: 18};
        vecs[4] = '{regs: zero_regs, rand_ready: 0, corrupt: 0, cksum: 8'h00, latency: 18};
        vecs[5] = '{regs: m17_regs,  rand_ready: 1, corrupt: 0, cksum: 8'hF8, latency: -1};
        vecs[6] = '{regs: h80_regs,  rand_ready: 1, corrupt: 1, cksum: 8'h00, latency: -1};

        Reset  = 1'b1;
        Start  = 1'b0;
        Abort  = 1'b0;
        Ready  = 1'b1;
        RegsIn = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_last",  {31'd0, Last},  32'd0);
        check("rst_busy",  {31'd0, Busy},  32'd0);
        check("rst_done",  {31'd0, Done},  32'd0);
        check("rst_data",  {24'd0, DataOut}, 32'd0);
        check("rst_addr",  {28'd0, AddrOut}, 32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) run_dump(vecs[i], $sformatf("vec%0d", i));

        // Start while busy is ignored, then abort with a beat on offer at index 5.
        RegsIn = inc_regs;
        push_dump(inc_regs, 8'h00, 5);
        @(posedge Clk); #1;
        Start = 1'b1;
        Ready = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        k = 0;
        while (!(Valid && AddrOut == PW'(5)) && k < 40) begin
            Start = Valid && (AddrOut == PW'(2));
            @(posedge Clk); #1;
            k++;
            if (Start) begin
                check("restart_busy", {31'd0, Busy}, 32'd1);
                check("restart_addr", {28'd0, AddrOut}, 32'd3);
            end
        end
        Start = 1'b0;
        check("abort_reached", {31'd0, (k < 40)}, 32'd1);
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        check("abort_valid", {31'd0, Valid}, 32'd0);
        check("abort_busy",  {31'd0, Busy},  32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", {31'd0, Done}, 32'd0);
            @(posedge Clk); #1;
        end
        check("abort_sb_empty", sb.size(), 32'd0);
        run_dump(vecs[0], "after_abort");

        // Asynchronous reset between edges in the middle of a dump.
        RegsIn = m17_regs;
        push_dump(m17_regs, 8'hF8, NREG);
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        check("pre_arst_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, Valid}, 32'd0);
        check("arst_last",  {31'd0, Last},  32'd0);
        check("arst_busy",  {31'd0, Busy},  32'd0);
        check("arst_done",  {31'd0, Done},  32'd0);
        check("arst_data",  {24'd0, DataOut}, 32'd0);
        check("arst_addr",  {28'd0, AddrOut}, 32'd0);
        sb.delete();
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("post_arst_valid", {31'd0, Valid}, 32'd0);
        run_dump(vecs[1], "after_arst");

        repeat (2) @(posedge Clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Read-side companion to the register file: on request, snapshots all 2**pw 8-bit register values in one cycle.
- Streams the snapshot out one register per beat over a valid/ready handshake, followed by one checksum beat.
- Sits between the register file's per-register value outputs and the debug/testbench trace port. It gives a coherent register dump while the core keeps executing.

Parameters:
- pw, 4, register address pointer width; the dump covers 2**pw registers.

Ports:
- Clk  input  1  clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a dump; sampled only in IDLE.
- Abort  input  1  synchronous cancel of an in-progress dump.
- RegsIn  input  8*2**pw  packed register values; bits [8i+7:8i] = register i.
- Ready  input  1  downstream accepts the current beat.
- Valid  output  1  DataOut/AddrOut/Last hold a beat.
- DataOut  output  8  register value, or checksum on the last beat.
- AddrOut  output  pw  register index of the beat; 0 on the checksum beat.
- Last  output  1  high only on the checksum beat.
- Busy  output  1  high in SEND and CKSUM.
- Done  output  1  one-cycle pulse after the checksum beat is accepted.

Behaviour:
- Reset (async, any state) values:
  - FSM goes to IDLE.
  - Valid, Last, Busy and Done are 0.
  - DataOut, AddrOut, the snapshot, the index counter and the checksum accumulator are all 0.
- States and transitions: IDLE, SEND, CKSUM, DONE.
- IDLE:
  - If Start=1, copy all of RegsIn into the snapshot, clear the index and the accumulator, and go to SEND.
  - Valid is 1 from the next cycle, i.e. the first beat appears 1 cycle after Start.
- SEND:
  - Valid=1, AddrOut=index, DataOut=snapshot[index].
  - A beat is accepted when Valid and Ready are both high at a posedge.
  - On acceptance: accumulator += DataOut (mod 256, 8-bit wrap), and index += 1.
  - When the accepted index is 2**pw-1, go to CKSUM; the index is not wrapped and is not used afterwards.
- CKSUM:
  - Valid=1, Last=1, AddrOut=0, DataOut=accumulator (sum of all snapshot bytes mod 256).
  - On acceptance, go to DONE.
- DONE:
  - Done=1 for exactly one cycle, Valid=0; then unconditionally go to IDLE.
  - Start in the DONE cycle is ignored.
- Handshake rules:
  - While Valid=1 and Ready=0, DataOut, AddrOut and Last are held stable.
  - Valid never drops without acceptance, except on Abort or Reset.
  - Ready held high gives one beat per cycle with no bubbles.
  - Ready may be high while Valid=0; this has no effect.
- Snapshot coherence: changes on RegsIn after the Start cycle do not affect the dump.
- Start while Busy=1 or in DONE: ignored; no restart and no queueing.
- Abort:
  - In SEND or CKSUM, go to IDLE at the next edge with Valid=0 and no Done pulse.
  - Abort takes priority over a simultaneous acceptance: the beat counts as not delivered.
  - In IDLE, Abort has priority over Start (nothing happens).
- Busy = (state==SEND || state==CKSUM).
- Beat count: a complete dump is exactly 2**pw + 1 accepted beats. Minimum latency from Start to Done is 2**pw + 2 cycles with Ready held high.

Test Plan:
- Register i = i+1 (1..16), Start pulse, Ready=1:
  - Beats are AddrOut 0..15 with DataOut 1..16, then Last=1 with DataOut=0x88 (sum 136).
  - Done pulses 18 cycles after Start.
- All registers = 0xFF, Ready=1: the checksum beat is 0xF0 (4080 mod 256), which checks the 8-bit wrap.
- Ready toggled 1,0,0,1 pseudo-randomly: every beat is held stable while Ready=0, no beat is lost or duplicated, and the 17 accepted beats match scenario 1.
- Change RegsIn to all 0xAA one cycle after Start: the dump still shows the pre-Start values, and the checksum matches the snapshot.
- Start asserted again during SEND: ignored, and Busy remains 1. Abort asserted on index 5 with Ready=1: Valid=0 the next cycle, no Done, and a new Start restarts from AddrOut=0.
- Reset asserted asynchronously (between edges) mid-SEND: all outputs go to 0 immediately without a clock edge, and the FSM is in IDLE.
